// File: rtl/sram_like_bridge.sv
// sram_like_bridge: serialises the core's inst and data SRAM ports onto one
// SRAM-like bus (addr_ok/data_ok). Stalls the core until every requested access
// completes and holds the returned read data for capture.
// Optional: define SRAM_BRIDGE_IBUF_EN to add a one-entry fetch buffer that
// satisfies a repeat fetch of the last completed inst address without the bus.
module sram_like_bridge #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_en_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_rdata_o,
  input  logic        data_en_i,
  input  logic [3:0]  data_wen_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_size_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_addr_ok_i,
  input  logic        mem_data_ok_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  // Irregular strobe patterns fall back to a word access.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return SizeByte;
      4'b0011, 4'b1100:                   return SizeHalf;
      default:                            return SizeWord;
    endcase
  endfunction

  state_e state_q, state_d;

  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic        sel_data_q, sel_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wr_q, mem_wr_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic inst_pending, data_pending;
  logic pick_data;
  logic ibuf_hit;
  logic launch;
  logic complete;

  assign inst_pending = inst_en_i & ~inst_done_q;
  assign data_pending = data_en_i & ~data_done_q;
  assign stall_o      = inst_pending | data_pending;

  assign pick_data = data_pending & (DATA_FIRST | ~inst_pending);
  assign launch    = (state_q == StIdle) & (inst_pending | data_pending) & ~ibuf_hit;
  // data_ok is only meaningful once the address phase is over.
  assign complete  = (state_q == StWait) & mem_data_ok_i;

`ifdef SRAM_BRIDGE_IBUF_EN
  logic        ibuf_valid_q, ibuf_valid_d;
  logic [31:0] ibuf_tag_q, ibuf_tag_d;

  // The buffered word is always the current inst_rdata, so only the tag is kept.
  assign ibuf_hit = (state_q == StIdle) & inst_pending & ~pick_data & ibuf_valid_q &
                    (ibuf_tag_q == inst_addr_i);

  // Fetch buffer next state: refill on inst completion, invalidate on any store.
  always_comb begin
    ibuf_valid_d = ibuf_valid_q;
    ibuf_tag_d   = ibuf_tag_q;
    if (complete) begin
      if (!sel_data_q) begin
        ibuf_valid_d = 1'b1;
        ibuf_tag_d   = mem_addr_q;
      end else if (mem_wr_q) begin
        ibuf_valid_d = 1'b0;
      end
    end
  end

  // Fetch buffer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ibuf_valid_q <= 1'b0;
      ibuf_tag_q   <= 32'h0;
    end else begin
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_tag_q   <= ibuf_tag_d;
    end
  end
`else
  assign ibuf_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (launch)        state_d = StReq;
      StReq:   if (mem_addr_ok_i) state_d = StWait;
      StWait:  if (mem_data_ok_i) state_d = StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  // FSM outputs: bus request registers, done flags and read data capture.
  always_comb begin
    sel_data_d   = sel_data_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_size_d   = mem_size_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = inst_done_q;
    data_done_d  = data_done_q;

    // The core advances on any unstalled edge, so completed ports are forgotten.
    if (!stall_o) begin
      inst_done_d = 1'b0;
      data_done_d = 1'b0;
    end

    if (launch) begin
      sel_data_d = pick_data;
      mem_req_d  = 1'b1;
      if (pick_data) begin
        mem_wr_d    = |data_wen_i;
        mem_size_d  = wen_to_size(data_wen_i);
        mem_wstrb_d = data_wen_i;
        mem_addr_d  = data_addr_i;
        mem_wdata_d = data_wdata_i;
      end else begin
        mem_wr_d    = 1'b0;
        mem_size_d  = SizeWord;
        mem_wstrb_d = 4'b0000;
        mem_addr_d  = inst_addr_i;
        mem_wdata_d = 32'h0;
      end
    end

    if (ibuf_hit) begin
      inst_done_d = 1'b1;
    end

    if ((state_q == StReq) && mem_addr_ok_i) begin
      mem_req_d = 1'b0;
    end

    // Completion wins over the unstalled clear so a dropped request still
    // records done for one cycle.
    if (complete) begin
      if (sel_data_q) begin
        data_done_d = 1'b1;
        if (!mem_wr_q) data_rdata_d = mem_rdata_i;
      end else begin
        inst_done_d  = 1'b1;
        inst_rdata_d = mem_rdata_i;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_data_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_size_q   <= 2'd0;
      mem_wstrb_q  <= 4'b0000;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
    end else begin
      sel_data_q   <= sel_data_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_size_q   <= mem_size_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_size_o   = mem_size_q;
  assign mem_wstrb_o  = mem_wstrb_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;

endmodule
